traffic_controller_np: RTL and testbench
========================================

# traffic_controller_np

Parametrised N-phase intersection controller, successor to the two-road highway/farm controller. It serves `NUM_PHASES` approaches with sensor-driven round-robin arbitration. Each phase gets minimum and maximum green times, a yellow interval, an all-red clearance interval, and a night flash mode. It sits between the debounced sensor inputs and the lamp-driver outputs on the Basys3 top level, and runs from a 1 s tick derived internally from `clk`.

## Interface
- `NUM_PHASES`, 4: number of approaches (2..8); phase 0 is the home (main-road) phase.
- `TICK_DIV`, 50_000_000: clk cycles per timing tick (1 s at 50 MHz; benches use 4).
- `GREEN_MIN`, 5: minimum green, in ticks (≥1).
- `GREEN_MAX`, 20: maximum green when another phase is waiting, in ticks (≥ `GREEN_MIN`).
- `YELLOW_T`, 3: yellow duration, in ticks (≥1).
- `ALLRED_T`, 1: all-red clearance, in ticks (≥1).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  `NUM_PHASES`  per-phase vehicle sensor, synchronous, level or pulse.
- `flash_en`  in  1  night flash mode request, synchronous.
- `lights`  out  `3*NUM_PHASES`  phase p at bits [3p+2:3p]; 3'b100 red, 3'b010 yellow, 3'b001 green, 3'b000 dark.
- `active_phase`  out  `$clog2(NUM_PHASES)`  phase currently owning green/yellow.
- `tick`  out  1  one-cycle tick strobe, for debug/LEDs.

## Operation
- Tick: the prescaler counts 0..`TICK_DIV`-1 and wraps; `tick`=1 on the cycle where the count equals `TICK_DIV`-1. The prescaler free-runs and is independent of the FSM.
- States: GREEN, YELLOW, ALLRED, FLASH.
  - `timer` clears on every state entry and increments on each `tick`.
  - "Elapsed D" means the tick when `timer`==D-1.
- Request latches, `pend[p]`:
  - set when `req[p]`=1 and p is not currently green;
  - cleared on the cycle phase p enters GREEN;
  - `req` for the phase currently in GREEN is ignored.
- Next-phase selection: the first p with `pend[p]`=1 scanning `active_phase`+1, +2, … with wrap (round-robin). It is computed at the YELLOW→ALLRED transition and loaded into `active_phase` at ALLRED→GREEN.
- GREEN(p) → YELLOW when any of:
  - elapsed ≥ `GREEN_MIN` and any `pend`=1;
  - elapsed = `GREEN_MAX` and any `pend`=1;
  - elapsed ≥ `GREEN_MIN` and `flash_en`=1.
- With no pending requests and no flash, GREEN holds indefinitely and `timer` saturates at `GREEN_MAX`.
- YELLOW → ALLRED after `YELLOW_T` elapsed.
- ALLRED → FLASH if `flash_en`=1. Otherwise → GREEN(selected phase), or GREEN(0) when nothing is pending.
- FLASH:
  - phase 0 alternates yellow/dark; every other phase alternates red/dark;
  - the toggle happens on each `tick`, starting lit;
  - `flash_en`=0 → ALLRED for `ALLRED_T`, then GREEN(0).
- Lights decode combinationally from the state register. Exactly one phase is non-red outside FLASH/ALLRED; all phases are red in ALLRED.
- Reset: GREEN, `active_phase`=0, `timer`=0, prescaler=0, `pend`=0, flash toggle lit. `lights` then shows phase 0 = 001 and all others = 100.

## Timing
- Sensor-to-latch latency is 1 cycle. A `req` pulse of one cycle is sufficient.
- Lights change in the same cycle the state register updates, which is the cycle after the qualifying tick.
- Simultaneous events:
  - `pend` set and clear for the same phase in one cycle: clear wins;
  - `flash_en` and pending requests both present at ALLRED exit: flash wins, and `pend` is retained;
  - GREEN_MIN and GREEN_MAX reached together (MIN=MAX): one transition.
- Min green is never shortened by `req` or `flash_en`.
- Mid-operation `rst_n` returns all state to reset values immediately, without waiting for a clock edge.

## Structure
- Shared header/package `traffic_pkg`: light encodings (RED/YEL/GRN/DARK), state encoding, and `LIGHT_W`=3.
- Sub-module `tick_gen` (parameter `TICK_DIV`; outputs the `tick` strobe), reusable by the other timed blocks.
- The top block contains the FSM, timer, request latches and round-robin selector.

## Test plan
All scenarios use `NUM_PHASES`=3, `TICK_DIV`=4, MIN=2, MAX=5, Y=3, AR=1.
- Reset then no `req` for 40 cycles → phase 0 green throughout, `active_phase`=0, `tick` every 4 cycles.
- `req[2]` one-cycle pulse at tick 0 → GREEN held to 2 ticks, then 3 ticks of yellow, 1 tick all-red, then `lights`=9'b001_100_100 (phase 2 green), `pend[2]`=0.
- `req[0]` and `req[1]` both held while phase 2 is green → phase 0 is served next (wrap), then phase 1. Each green lasts exactly MIN.
- `req[1]` held throughout while in phase 0 before MIN → phase 0 stays green for exactly 2 ticks. A request arriving after a 5-tick green cannot extend it beyond MAX.
- `flash_en`=1 during phase-1 green at tick 0 → yellow after MIN, then all-red, then FLASH with phase 0 toggling 010/000 and others 100/000 per tick. Deassert → 1 tick all-red, then phase 0 green.
- Assert `rst_n`=0 mid-YELLOW for 2 cycles → outputs return to reset values asynchronously, and the sequence restarts from GREEN(0) with `pend` cleared.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_pkg : lamp encodings and FSM state codes for traffic blocks  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package traffic_pkg;

  localparam int LIGHT_W = 3;

  localparam logic [LIGHT_W-1:0] RED  = 3'b100;
  localparam logic [LIGHT_W-1:0] YEL  = 3'b010;
  localparam logic [LIGHT_W-1:0] GRN  = 3'b001;
  localparam logic [LIGHT_W-1:0] DARK = 3'b000;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_GREEN  = 2'd0;
  localparam logic [ST_W-1:0] ST_YELLOW = 2'd1;
  localparam logic [ST_W-1:0] ST_ALLRED = 2'd2;
  localparam logic [ST_W-1:0] ST_FLASH  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_gen : free-running prescaler, one-cycle strobe every TICK_DIV   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TICK_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_cnt <= '0;
    else if (r_cnt == c_LAST) r_cnt <= '0;
    else                      r_cnt <= r_cnt + c_CNT_W'(1);
  end

  assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/traffic_controller_np.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_controller_np : N-phase round-robin intersection controller  |
// | Revision              : 1.0                                          |
// +----------------------------------------------------------------------+
module traffic_controller_np
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int TICK_DIV   = 50_000_000,
  parameter int GREEN_MIN  = 5,
  parameter int GREEN_MAX  = 20,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PHASES-1:0]           req,
  input  logic                            flash_en,
  output logic [LIGHT_W*NUM_PHASES-1:0]   lights,
  output logic [$clog2(NUM_PHASES)-1:0]   active_phase,
  output logic                            tick
);

  localparam int c_PH_W    = $clog2(NUM_PHASES);
  localparam int c_TMR_MAX = (GREEN_MAX > YELLOW_T) ?
                             ((GREEN_MAX > ALLRED_T) ? GREEN_MAX : ALLRED_T) :
                             ((YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T);
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

  localparam logic [c_TMR_W-1:0] c_GMIN_M1 = c_TMR_W'(GREEN_MIN - 1);
  localparam logic [c_TMR_W-1:0] c_GMAX    = c_TMR_W'(GREEN_MAX);
  localparam logic [c_TMR_W-1:0] c_Y_M1    = c_TMR_W'(YELLOW_T - 1);
  localparam logic [c_TMR_W-1:0] c_AR_M1   = c_TMR_W'(ALLRED_T - 1);
  localparam logic [c_TMR_W-1:0] c_TSAT    = c_TMR_W'(c_TMR_MAX);

  logic [ST_W-1:0]       r_state, w_state_nxt;
  logic [c_TMR_W-1:0]    r_timer, w_tmr_sat;
  logic [NUM_PHASES-1:0] r_pend, w_pend_set, w_pend_clr;
  logic [c_PH_W-1:0]     r_active, r_next_phase, w_sel_phase;
  logic                  w_sel_valid, r_lit, w_tick, w_enter_green;
  int                    w_dist, w_best;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_GREEN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_GREEN:  if (w_tick && (r_timer >= c_GMIN_M1) && ((|r_pend) || flash_en))
                   w_state_nxt = ST_YELLOW;
      ST_YELLOW: if (w_tick && (r_timer == c_Y_M1)) w_state_nxt = ST_ALLRED;
      ST_ALLRED: if (w_tick && (r_timer == c_AR_M1))
                   w_state_nxt = flash_en ? ST_FLASH : ST_GREEN;
      ST_FLASH:  if (!flash_en) w_state_nxt = ST_ALLRED;
      default:   w_state_nxt = ST_GREEN;
    endcase
  end

  assign w_enter_green = (r_state == ST_ALLRED) && (w_state_nxt == ST_GREEN);

  // Round-robin pick: smallest forward distance from the active phase, itself last.
  always_comb begin
    w_sel_phase = '0;
    w_sel_valid = |r_pend;
    w_best      = NUM_PHASES;
    w_dist      = 0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      w_dist = p - int'(r_active) - 1;
      if (w_dist < 0) w_dist = w_dist + NUM_PHASES;
      if (r_pend[p] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_sel_phase = c_PH_W'(p);
      end
    end
  end

  always_comb begin
    w_pend_set = '0;
    w_pend_clr = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      w_pend_set[p] = req[p] && !((r_state == ST_GREEN) && (r_active == c_PH_W'(p)));
      w_pend_clr[p] = w_enter_green && (r_next_phase == c_PH_W'(p));
    end
  end

  assign w_tmr_sat = (r_state == ST_GREEN) ? c_GMAX : c_TSAT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_timer <= '0;
    else if (w_state_nxt != r_state)         r_timer <= '0;
    else if (w_tick && (r_timer != w_tmr_sat)) r_timer <= r_timer + c_TMR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= (r_pend | w_pend_set) & ~w_pend_clr;
  end

  // Leaving flash always returns to the home phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active     <= '0;
      r_next_phase <= '0;
    end else begin
      if ((r_state == ST_YELLOW) && (w_state_nxt == ST_ALLRED))
        r_next_phase <= w_sel_valid ? w_sel_phase : '0;
      else if ((r_state == ST_FLASH) && (w_state_nxt == ST_ALLRED))
        r_next_phase <= '0;
      if (w_enter_green) r_active <= r_next_phase;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              r_lit <= 1'b1;
    else if ((w_state_nxt == ST_FLASH) && (r_state != ST_FLASH)) r_lit <= 1'b1;
    else if ((r_state == ST_FLASH) && w_tick)                r_lit <= ~r_lit;
  end

  always_comb begin
    lights = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      case (r_state)
        ST_GREEN:  lights[LIGHT_W*p +: LIGHT_W] = (r_active == c_PH_W'(p)) ? GRN : RED;
        ST_YELLOW: lights[LIGHT_W*p +: LIGHT_W] = (r_active == c_PH_W'(p)) ? YEL : RED;
        ST_ALLRED: lights[LIGHT_W*p +: LIGHT_W] = RED;
        default:   lights[LIGHT_W*p +: LIGHT_W] = !r_lit ? DARK : ((p == 0) ? YEL : RED);
      endcase
    end
  end

  assign active_phase = r_active;
  assign tick         = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_traffic_controller_np.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_traffic_controller_np : directed + random bench, reference model  |
// | Revision                 : 1.0                                       |
// +----------------------------------------------------------------------+
module tb_traffic_controller_np;

  localparam int NP   = 3;
  localparam int TD   = 4;
  localparam int GMIN = 2;
  localparam int GMAX = 5;
  localparam int YT   = 3;
  localparam int ART  = 1;
  localparam logic [3*NP-1:0] c_HOME = 9'b100_100_001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] req = '0;
  logic          flash_en = 1'b0;
  logic [3*NP-1:0] lights;
  logic [1:0]    active_phase;
  logic          tick;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  traffic_controller_np #(
    .NUM_PHASES (NP),
    .TICK_DIV   (TD),
    .GREEN_MIN  (GMIN),
    .GREEN_MAX  (GMAX),
    .YELLOW_T   (YT),
    .ALLRED_T   (ART)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .flash_en     (flash_en),
    .lights       (lights),
    .active_phase (active_phase),
    .tick         (tick)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0 green, 1 yellow, 2 all-red, 3 flash; ticks counted since mode entry.
  int m_mode = 0, m_phase = 0, m_next = 0, m_ticks = 0, m_cycles = 0;
  bit m_lit = 1'b1;
  bit m_pend [NP];

  function automatic int pick_next();
    for (int k = 1; k <= NP; k++)
      if (m_pend[(m_phase + k) % NP]) return (m_phase + k) % NP;
    return 0;
  endfunction

  task automatic model_step();
    bit t;
    int new_mode, enter;
    bit any;
    t = (m_cycles % TD) == (TD - 1);
    m_cycles++;
    new_mode = m_mode;
    enter = -1;
    any = 1'b0;
    for (int p = 0; p < NP; p++) any |= m_pend[p];
    case (m_mode)
      0: if (t && (m_ticks + 1 >= GMIN) && (any || flash_en)) new_mode = 1;
      1: if (t && (m_ticks + 1 == YT)) begin new_mode = 2; m_next = pick_next(); end
      2: if (t && (m_ticks + 1 == ART)) begin
           if (flash_en) new_mode = 3;
           else begin new_mode = 0; enter = m_next; end
         end
      default: if (!flash_en) begin new_mode = 2; m_next = 0; end
               else if (t) m_lit = !m_lit;
    endcase
    for (int p = 0; p < NP; p++)
      if (req[p] && !(m_mode == 0 && m_phase == p)) m_pend[p] = 1'b1;
    if (enter >= 0) begin m_pend[enter] = 1'b0; m_phase = enter; end
    if (new_mode != m_mode) begin
      m_ticks = 0;
      if (new_mode == 3) m_lit = 1'b1;
    end else if (t) m_ticks++;
    m_mode = new_mode;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_phase = 0; m_next = 0; m_ticks = 0; m_cycles = 0; m_lit = 1'b1;
      for (int p = 0; p < NP; p++) m_pend[p] = 1'b0;
    end else model_step();
  end

  function automatic logic [3*NP-1:0] exp_lights();
    logic [3*NP-1:0] v;
    logic [2:0] s;
    v = '0;
    for (int p = 0; p < NP; p++) begin
      case (m_mode)
        0:       s = (p == m_phase) ? 3'b001 : 3'b100;
        1:       s = (p == m_phase) ? 3'b010 : 3'b100;
        2:       s = 3'b100;
        default: s = !m_lit ? 3'b000 : ((p == 0) ? 3'b010 : 3'b100);
      endcase
      v[3*p +: 3] = s;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check_val("lights", lights, exp_lights());
      check_val("active_phase", active_phase, m_phase);
      check_val("tick", tick, (m_cycles % TD) == (TD - 1));
    end
  end

  task automatic wait_phase(input int ph, input int budget);
    int n = 0;
    while ((active_phase !== 2'(ph)) && (n < budget)) begin @(negedge clk); n++; end
    check_val("wait_phase", active_phase, ph);
  endtask

  task automatic wait_lights(input logic [3*NP-1:0] pat, input int budget);
    int n = 0;
    while ((lights !== pat) && (n < budget)) begin @(negedge clk); n++; end
    check_val("wait_lights", lights, pat);
  endtask

  task automatic wait_tick();
    int n = 0;
    while ((tick !== 1'b1) && (n < 2*TD)) begin @(negedge clk); n++; end
    check_val("wait_tick", tick, 1);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check_val("reset_lights", lights, c_HOME);
    check_val("reset_phase", active_phase, 0);
    #1 rst_n = 1'b1;

    repeat (40) begin @(negedge clk); check_val("idle_lights", lights, c_HOME); end

    // Single-cycle request on phase 2 aligned with a tick.
    wait_tick();
    #1 req = 3'b100;
    @(negedge clk); #1 req = '0;
    wait_phase(2, 100);
    check_val("ph2_green", lights, 9'b001_100_100);

    // Phases 0 and 1 held while phase 2 is green: wrap to 0, then 1.
    #1 req = 3'b011;
    wait_phase(0, 100);
    check_val("ph0_green", lights, c_HOME);
    wait_phase(1, 100);
    check_val("ph1_green", lights, 9'b100_001_100);
    #1 req = '0;

    // Night flash requested during phase-1 green.
    wait_tick();
    #1 flash_en = 1'b1;
    wait_lights(9'b100_100_010, 150);
    repeat (20) @(negedge clk);
    #1 flash_en = 1'b0;
    wait_lights(9'b100_100_100, 20);
    wait_lights(c_HOME, 20);

    // Asynchronous reset in the middle of yellow.
    wait_phase(0, 100);
    #1 req = 3'b010;
    @(negedge clk); #1 req = '0;
    n = 0;
    while ((lights[3*active_phase +: 3] !== 3'b010) && (n < 100)) begin @(negedge clk); n++; end
    check_val("reached_yellow", lights[3*active_phase +: 3], 3'b010);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_lights", lights, c_HOME);
    check_val("async_rst_phase", active_phase, 0);
    check_val("async_rst_tick", tick, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_val("post_rst_hold", lights, c_HOME);

    // Randomised traffic with occasional flash windows.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk); #1;
      req = ($urandom_range(0, 5) == 0) ? NP'($urandom) : '0;
      if ($urandom_range(0, 249) == 0) flash_en = ~flash_en;
    end
    #1 flash_en = 1'b0; req = '0;
    repeat (60) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
